// File: rtl/histogram_accumulator_if.sv
// Pixel stream and histogram RAM port of the histogram accumulator.
// The slave modport is the accumulator's view; master is the pixel source / RAM side.
interface histogram_accumulator_if #(
    parameter int unsigned word_size = 20
);
    logic [7:0]           iPixel;
    logic                 iValid;
    logic                 oReady;
    logic [7:0]           oRdAddr;
    logic [word_size-1:0] iRdData;
    logic [7:0]           oWrAddr;
    logic [word_size-1:0] oWrData;
    logic                 oWE;

    modport slave (
        input  iPixel, iValid, iRdData,
        output oReady, oRdAddr, oWrAddr, oWrData, oWE
    );

    modport master (
        output iPixel, iValid, iRdData,
        input  oReady, oRdAddr, oWrAddr, oWrData, oWE
    );
endinterface

// File: rtl/histogram_accumulator.sv
// 256-bin intensity histogram builder. Clears the histogram RAM, then counts
// each accepted pixel by a 3-stage read-modify-write with write forwarding so
// back-to-back pixels of the same value are counted exactly.
module histogram_accumulator #(
    parameter int unsigned word_size  = 20,
    parameter int unsigned num_pixels = 800 * 480
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iStart,
    histogram_accumulator_if.slave   bus,
    output logic [18:0]              oPixelCount,
    output logic                     oDone
);

    typedef enum logic [2:0] {StIdle, StClear, StAccum, StDrain, StDone} state_e;

    localparam logic [18:0]          PixelLimit = 19'(num_pixels);
    localparam logic [word_size-1:0] CountMax   = '1;

    state_e               state_q;
    logic [1:0]           drain_cnt_q;
    logic                 s1_valid_q;
    logic                 s2_valid_q;
    logic [7:0]           s2_addr_q;
    logic                 lc_valid_q;
    logic [7:0]           lc_addr_q;
    logic [word_size-1:0] lc_data_q;

    logic                 accept;
    logic                 s3_valid;
    logic [word_size-1:0] fwd;
    logic [word_size-1:0] new_count;

    // Accept qualification, stage-3 validity and forwarded increment for stage 2.
    always_comb begin
        accept    = (state_q == StAccum) && bus.iValid && bus.oReady;
        // The write port carries clear writes in CLEAR; only pipeline writes are stage 3.
        s3_valid  = bus.oWE && (state_q != StClear);
        fwd       = bus.iRdData;
        if (lc_valid_q && (lc_addr_q == s2_addr_q)) begin
            fwd = lc_data_q;
        end
        // Stage 3 is newer than the last committed write, so it wins.
        if (s3_valid && (bus.oWrAddr == s2_addr_q)) begin
            fwd = bus.oWrData;
        end
        new_count = (fwd == CountMax) ? fwd : fwd + word_size'(1);
    end

    // Control FSM plus registered pipeline and RAM port outputs.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= StIdle;
            drain_cnt_q <= 2'd0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= 8'd0;
            lc_valid_q  <= 1'b0;
            lc_addr_q   <= 8'd0;
            lc_data_q   <= '0;
            bus.oReady  <= 1'b0;
            bus.oRdAddr <= 8'd0;
            bus.oWrAddr <= 8'd0;
            bus.oWrData <= '0;
            bus.oWE     <= 1'b0;
            oPixelCount <= 19'd0;
            oDone       <= 1'b0;
        end else if (iStart) begin
            // Abort everything in flight and issue the first clear write next cycle.
            state_q     <= StClear;
            drain_cnt_q <= 2'd0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            lc_valid_q  <= 1'b0;
            bus.oReady  <= 1'b0;
            bus.oWrAddr <= 8'd0;
            bus.oWrData <= '0;
            bus.oWE     <= 1'b1;
            oPixelCount <= 19'd0;
            oDone       <= 1'b0;
        end else begin
            oDone <= 1'b0;

            // Stage 1: present the read address of the accepted pixel.
            s1_valid_q <= accept;
            if (accept) begin
                bus.oRdAddr <= bus.iPixel;
            end

            // Stage 2: read data arrives next cycle for this address.
            s2_valid_q <= s1_valid_q;
            s2_addr_q  <= bus.oRdAddr;

            // Stage 3: registered write of the incremented count.
            bus.oWE <= s2_valid_q;
            if (s2_valid_q) begin
                bus.oWrAddr <= s2_addr_q;
                bus.oWrData <= new_count;
            end

            // Remember the write committing this cycle; a read issued now misses it.
            lc_valid_q <= s3_valid;
            lc_addr_q  <= bus.oWrAddr;
            lc_data_q  <= bus.oWrData;

            if (accept) begin
                oPixelCount <= oPixelCount + 19'd1;
                if (oPixelCount + 19'd1 == PixelLimit) begin
                    bus.oReady <= 1'b0;
                end
            end

            case (state_q)
                StIdle: begin
                end
                StClear: begin
                    if (bus.oWrAddr == 8'hFF) begin
                        state_q    <= StAccum;
                        bus.oReady <= 1'b1;
                    end else begin
                        bus.oWE     <= 1'b1;
                        bus.oWrAddr <= bus.oWrAddr + 8'd1;
                        bus.oWrData <= '0;
                    end
                end
                StAccum: begin
                    if (oPixelCount == PixelLimit) begin
                        state_q     <= StDrain;
                        drain_cnt_q <= 2'd0;
                    end
                end
                StDrain: begin
                    if (drain_cnt_q == 2'd2) begin
                        state_q <= StDone;
                        oDone   <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_histogram_accumulator.sv
// Bench for histogram_accumulator: a wide instance and a 3-bit saturating instance,
// each with a behavioural RAM; frames are checked write-by-write against a counting model.
module tb_histogram_accumulator;

    localparam int unsigned MainWs = 20;
    localparam int unsigned MainN  = 512;
    localparam int unsigned SatWs  = 3;
    localparam int unsigned SatN   = 10;

    typedef struct {
        bit               sel;    // 0: wide instance, 1: saturating instance
        int               kind;   // pixel pattern
        int               gap;    // percent of idle cycles
        int               nchk;   // number of hand-computed bins to check
        logic [2:0][7:0]  bin;
        logic [2:0][19:0] cnt;
    } vec_t;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       tb_start;
    logic       tb_valid;
    logic [7:0] tb_pixel;
    logic       sel;

    always #5 iClk = ~iClk;

    histogram_accumulator_if #(.word_size(MainWs)) bus_m ();
    histogram_accumulator_if #(.word_size(SatWs))  bus_s ();

    logic        start_m, start_s, done_m, done_s;
    logic [18:0] cnt_m, cnt_s;

    assign start_m      = tb_start & ~sel;
    assign start_s      = tb_start & sel;
    assign bus_m.iValid = tb_valid & ~sel;
    assign bus_s.iValid = tb_valid & sel;
    assign bus_m.iPixel = tb_pixel;
    assign bus_s.iPixel = tb_pixel;

    histogram_accumulator #(.word_size(MainWs), .num_pixels(MainN)) u_main (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iStart      (start_m),
        .bus         (bus_m),
        .oPixelCount (cnt_m),
        .oDone       (done_m)
    );

    histogram_accumulator #(.word_size(SatWs), .num_pixels(SatN)) u_sat (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iStart      (start_s),
        .bus         (bus_s),
        .oPixelCount (cnt_s),
        .oDone       (done_s)
    );

    // Behavioural RAMs: registered read, same-address read returns old data.
    // Filled with junk during reset so a missing clear shows up.
    logic [MainWs-1:0] ram_m [256];
    logic [SatWs-1:0]  ram_s [256];

    always @(posedge iClk) begin
        if (!iRst_n) begin
            for (int i = 0; i < 256; i++) ram_m[i] <= 20'h5A5A5;
        end else begin
            bus_m.iRdData <= ram_m[bus_m.oRdAddr];
            if (bus_m.oWE) ram_m[bus_m.oWrAddr] <= bus_m.oWrData;
        end
    end

    always @(posedge iClk) begin
        if (!iRst_n) begin
            for (int i = 0; i < 256; i++) ram_s[i] <= 3'h5;
        end else begin
            bus_s.iRdData <= ram_s[bus_s.oRdAddr];
            if (bus_s.oWE) ram_s[bus_s.oWrAddr] <= bus_s.oWrData;
        end
    end

    // View of the selected instance.
    logic        cur_we, cur_ready, cur_done;
    logic [7:0]  cur_wr_addr;
    logic [19:0] cur_wr_data;
    logic [18:0] cur_count;

    assign cur_we      = sel ? bus_s.oWE : bus_m.oWE;
    assign cur_ready   = sel ? bus_s.oReady : bus_m.oReady;
    assign cur_done    = sel ? done_s : done_m;
    assign cur_wr_addr = sel ? bus_s.oWrAddr : bus_m.oWrAddr;
    assign cur_wr_data = sel ? 20'(bus_s.oWrData) : bus_m.oWrData;
    assign cur_count   = sel ? cnt_s : cnt_m;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_cnt [256];
    int wq_addr [$];
    int wq_data [$];
    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ram_at(input logic [7:0] b);
        return sel ? int'(ram_s[b]) : int'(ram_m[b]);
    endfunction

    function automatic logic [7:0] pix_of(input int kind, input int i);
        case (kind)
            0: return 8'd7;
            1: return 8'(i % 256);
            2: begin
                case (i % 8)
                    1, 3:    return 8'd5;
                    6:       return 8'd9;
                    default: return 8'd3;
                endcase
            end
            3: return 8'($urandom_range(255));
            4: return 8'($urandom_range(3));
            default: return 8'd0;
        endcase
    endfunction

    task automatic do_start();
        @(posedge iClk); #1 tb_start = 1'b1;
        @(posedge iClk); #1 tb_start = 1'b0;
    endtask

    // 256 consecutive zero writes at ascending addresses, starting right after iStart.
    task automatic check_clear();
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < 256; i++) begin
            @(negedge iClk);
            if (i == 0) begin
                chk("clear_pixcount", int'(cur_count), 0);
                chk("clear_done_low", int'(cur_done), 0);
            end
            if (!(cur_we && cur_wr_addr == 8'(i) && cur_wr_data == '0)) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (bad != 0) $display("first bad clear cycle %0d", first);
        chk("clear_bad_cycles", bad, 0);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0] px [1024];
        int n, maxc, done_cnt, done_c, last_we, acc;
        sel = v.sel;
        n = sel ? int'(SatN) : int'(MainN);
        maxc = sel ? 7 : 1048575;
        done_cnt = 0;
        done_c = -100;
        last_we = -1;
        acc = 0;
        for (int b = 0; b < 256; b++) exp_cnt[b] = 0;
        wq_addr.delete();
        wq_data.delete();
        for (int i = 0; i < n; i++) px[i] = pix_of(v.kind, i);
        do_start();
        check_clear();
        fork
            begin : drv_blk
                int i;
                int g;
                i = 0;
                g = 0;
                while (i < n && g < 8 * n + 64) begin
                    @(posedge iClk); #1;
                    if ($urandom_range(99) < v.gap) begin
                        tb_valid = 1'b0;
                    end else begin
                        tb_valid = 1'b1;
                        tb_pixel = px[i];
                    end
                    @(negedge iClk);
                    if (tb_valid && cur_ready) i++;
                    g++;
                end
                // Extra valid pixels after the frame must be ignored.
                for (int k = 0; k < 4; k++) begin
                    @(posedge iClk); #1;
                    tb_valid = 1'b1;
                    tb_pixel = 8'($urandom);
                end
                @(posedge iClk); #1 tb_valid = 1'b0;
            end
            begin : mon_blk
                logic [7:0] p;
                int pend;
                for (int c = 0; c < 8 * n + 200; c++) begin
                    @(negedge iClk);
                    if (tb_valid && cur_ready) begin
                        p = tb_pixel;
                        if (exp_cnt[p] < maxc) exp_cnt[p]++;
                        wq_addr.push_back(int'(p));
                        wq_data.push_back(exp_cnt[p]);
                        acc++;
                    end
                    if (cur_we) begin
                        last_we = c;
                        pend = wq_addr.size();
                        chk("write_has_pending_pixel", int'(pend > 0), 1);
                        if (pend > 0) begin
                            chk("write_addr", int'(cur_wr_addr), wq_addr.pop_front());
                            chk("write_data", int'(cur_wr_data), wq_data.pop_front());
                        end
                    end
                    if (cur_done) begin
                        done_cnt++;
                        done_c = c;
                    end
                    if (done_cnt > 0 && c >= done_c + 3) break;
                end
            end
        join
        chk("done_pulses", done_cnt, 1);
        chk("done_after_last_write", done_c - last_we, 2);
        chk("writes_outstanding", wq_addr.size(), 0);
        chk("model_accepts", acc, n);
        chk("pixel_count", int'(cur_count), n);
        chk("ready_after_frame", int'(cur_ready), 0);
        chk("we_idle", int'(cur_we), 0);
        for (int b = 0; b < 256; b++) begin
            chk($sformatf("ram_bin%0d", b), ram_at(8'(b)), exp_cnt[b]);
        end
        for (int k = 0; k < v.nchk; k++) begin
            chk($sformatf("table_bin%0d", v.bin[k]), ram_at(v.bin[k]), int'(v.cnt[k]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int g;
        int we_seen;
        int done_seen;

        vecs[0] = '{1'b0, 0, 0,  3, {8'd8, 8'd0, 8'd7},     {20'd0, 20'd0, 20'd512}};
        vecs[1] = '{1'b0, 2, 30, 3, {8'd9, 8'd5, 8'd3},     {20'd64, 20'd128, 20'd320}};
        vecs[2] = '{1'b0, 1, 10, 3, {8'd255, 8'd128, 8'd0}, {20'd2, 20'd2, 20'd2}};
        vecs[3] = '{1'b0, 3, 25, 0, {8'd0, 8'd0, 8'd0},     {20'd0, 20'd0, 20'd0}};
        vecs[4] = '{1'b0, 4, 0,  0, {8'd0, 8'd0, 8'd0},     {20'd0, 20'd0, 20'd0}};
        vecs[5] = '{1'b1, 5, 0,  3, {8'd255, 8'd1, 8'd0},   {20'd0, 20'd0, 20'd7}};
        vecs[6] = '{1'b1, 5, 40, 3, {8'd255, 8'd1, 8'd0},   {20'd0, 20'd0, 20'd7}};

        iRst_n   = 1'b0;
        tb_start = 1'b0;
        tb_valid = 1'b0;
        tb_pixel = 8'd0;
        sel      = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        chk("rst_ready", int'(bus_m.oReady), 0);
        chk("rst_rdaddr", int'(bus_m.oRdAddr), 0);
        chk("rst_wraddr", int'(bus_m.oWrAddr), 0);
        chk("rst_wrdata", int'(bus_m.oWrData), 0);
        chk("rst_we", int'(bus_m.oWE), 0);
        chk("rst_pixcount", int'(cnt_m), 0);
        chk("rst_done", int'(done_m), 0);
        @(posedge iClk); #2 iRst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        // iStart during DRAIN: clean restart at address 0, nothing stale afterwards.
        sel = 1'b1;
        do_start();
        check_clear();
        g = 0;
        while (cur_count < 19'(SatN) && g < 100) begin
            @(posedge iClk); #1;
            tb_valid = 1'b1;
            tb_pixel = 8'd0;
            @(negedge iClk);
            g++;
        end
        @(posedge iClk); #1 tb_valid = 1'b0;
        do_start();
        check_clear();
        we_seen = 0;
        done_seen = 0;
        repeat (8) begin
            @(negedge iClk);
            if (cur_we) we_seen++;
            if (cur_done) done_seen++;
        end
        chk("restart_stale_writes", we_seen, 0);
        chk("restart_stale_done", done_seen, 0);
        chk("restart_bin0", ram_at(8'd0), 0);
        chk("restart_ready", int'(cur_ready), 1);

        // Asynchronous reset in the middle of accumulation.
        sel = 1'b0;
        do_start();
        check_clear();
        @(posedge iClk); #1;
        tb_valid = 1'b1;
        tb_pixel = 8'd7;
        repeat (20) @(posedge iClk);
        #2 iRst_n = 1'b0;
        #1;
        chk("async_rst_ready", int'(bus_m.oReady), 0);
        chk("async_rst_rdaddr", int'(bus_m.oRdAddr), 0);
        chk("async_rst_wraddr", int'(bus_m.oWrAddr), 0);
        chk("async_rst_wrdata", int'(bus_m.oWrData), 0);
        chk("async_rst_we", int'(bus_m.oWE), 0);
        chk("async_rst_pixcount", int'(cnt_m), 0);
        chk("async_rst_done", int'(done_m), 0);
        @(posedge iClk); #2 iRst_n = 1'b1;
        we_seen = 0;
        repeat (5) begin
            @(negedge iClk);
            if (bus_m.oWE) we_seen++;
        end
        chk("post_rst_idle_writes", we_seen, 0);
        chk("post_rst_ready", int'(bus_m.oReady), 0);
        chk("post_rst_pixcount", int'(cnt_m), 0);
        tb_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/histogram_accumulator.md
Name: histogram_accumulator

Overview:
Builds the 256-bin intensity histogram of one 800x480 greyscale frame into the histogram RAM. The cumulative-histogram/threshold stage reads that RAM. The block clears the RAM, then counts each incoming pixel by read-modify-write. It forwards in-flight results so back-to-back pixels of the same value count exactly. It pulses oDone when the RAM holds the final histogram for the frame.

Parameters:
word_size, 20, bin count width (must hold num_pixels)
num_pixels, 800*480, pixels accepted per frame before the block finishes

Ports:
iClk  in  1  clock
iRst_n  in  1  reset; asynchronous and active-low
iStart  in  1  one-cycle pulse: abort any work, clear RAM, begin a new frame
iPixel  in  8  pixel intensity (bin index)
iValid  in  1  iPixel valid; accepted only when oReady=1
oReady  out  1  high while in ACCUM and fewer than num_pixels accepted
oRdAddr  out  8  histogram RAM read address (registered)
iRdData  in  word_size  RAM read data; reflects the oRdAddr presented in the previous cycle
oWrAddr  out  8  histogram RAM write address (registered)
oWrData  out  word_size  histogram RAM write data (registered)
oWE  out  1  RAM write enable; a write commits at the clock edge ending the cycle in which oWE=1
oPixelCount  out  19  pixels accepted this frame
oDone  out  1  one-cycle pulse when the histogram is complete

Behaviour:
- Reset (async, iRst_n=0): state=IDLE; oReady=0, oRdAddr=0, oWrAddr=0, oWrData=0, oWE=0, oPixelCount=0, oDone=0; pipeline valid bits cleared.
- RAM model: a read in the same cycle as a write to the same address returns OLD data. No other RAM behaviour is relied on.
- States: IDLE -> CLEAR -> ACCUM -> DRAIN -> DONE -> IDLE.
- iStart=1 in any state: next state CLEAR, clear address=0, pipeline valid bits cleared, oPixelCount=0, oDone=0. iStart has priority over every other event.
- CLEAR: each cycle oWE=1, oWrData=0, oWrAddr=0,1,...,255 (256 cycles). After address 255 -> ACCUM.
- ACCUM: oReady=1 until oPixelCount==num_pixels. A pixel is accepted when iValid & oReady; iValid is ignored in every other state.
- Pipeline for a pixel p accepted in cycle t:
  - t+1: oRdAddr=p.
  - t+2: iRdData=stored count(p); new count = fwd(p)+1 is computed.
  - t+3: oWrAddr=p, oWrData=new count, oWE=1.
- Forwarding: fwd(p) uses the newest value for bin p that the RAM read may have missed.
  - First choice: the stage-3 register, if valid and its address is p (write visible this cycle, committing now).
  - Second choice: the last-committed register, if valid and its address is p (write committed at the end of the previous cycle).
  - Otherwise: iRdData.
- Increment saturates at 2^word_size-1 and never wraps.
- oWE=0 in any cycle with no valid stage-3 entry, except in CLEAR.
- oPixelCount increments on every accept; it stops at num_pixels.
- When oPixelCount reaches num_pixels -> DRAIN. oReady drops the cycle after the last accept.
- DRAIN: 3 cycles, during which the final writes issue. Then -> DONE.
- DONE: oDone=1 for exactly one cycle; oWE=0; -> IDLE.
- Gaps in iValid are allowed anywhere in ACCUM; bubbles carry no write.
- IDLE: all RAM outputs quiescent (oWE=0). oPixelCount holds its final value.
- Latency: last accepted pixel's write is visible at t+3; oDone at t+5 (RAM final at the end of t+3).

Test Plan:
- Reset mid-ACCUM: assert iRst_n=0 -> all outputs 0 immediately (async), state IDLE, oWE=0.
- iStart, then check CLEAR -> exactly 256 consecutive oWE=1 cycles with oWrData=0 at addresses 0..255 in order.
- num_pixels=16, all 16 pixels=8'd7 back-to-back -> final RAM bin7=16, other bins 0. The write sequence for bin 7 is 1,2,...,16, exercising the forwarding path.
- num_pixels=8, pattern 3,5,3,5,3,3,9,3 with random iValid gaps -> bin3=5, bin5=2, bin9=1. oDone pulses once, exactly 2 cycles after the last oWE.
- Full-frame default params, uniform ramp pixel=i%256 -> every bin = 1500. oPixelCount=384000. oReady=0 after the last accept; extra iValid ignored.
- word_size=3, num_pixels=10, all pixels 0 -> bin0 saturates at 7 and does not wrap. iStart pulsed mid-DRAIN -> restarts CLEAR at address 0 with no stale write.
